// File: rtl/regfile_hist.sv
// regfile_hist: register file for the puzzle-solver CPU, plus a move-history
// stack used for depth-first backtracking.
//
// Optional build macro: REGFILE_BYPASS_EN. When it is defined, a read whose
// address matches the write address in the same cycle returns the write data.
// When it is not defined, such a read returns the stored (old) value.
//
// Ports:
//   clk, rst_n          rising-edge clock; asynchronous active-low reset
//   src0/src1 -> data0/data1
//                       two combinational read ports; out-of-range reads give 0
//   dst, we, data       synchronous write port; out-of-range dst is ignored
//   push, pop, move, hist_clr
//                       stack operations; push+pop together replaces the top
//   top, cnt, ord       top move, stack depth, and all entries packed together
//   full, empty         stack status
//   ovf, unf            sticky overflow/underflow flags, cleared by hist_clr
//   comp                bit 0 of register COMP_IDX
module regfile_hist #(
  parameter int          DATA_W     = 26,
  parameter int          NREG       = 32,
  parameter logic [25:0] INIT_STATE = 26'h0A720C1,
  parameter logic [25:0] GOAL_STATE = 26'h0000053,
  parameter int          COMP_IDX   = 30,
  parameter int          MOVE_W     = 2,
  parameter int          HIST_DEPTH = 20,
  localparam int         AW         = $clog2(NREG),
  localparam int         DW         = $clog2(HIST_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AW-1:0]                src0,
  input  logic [AW-1:0]                src1,
  input  logic [AW-1:0]                dst,
  input  logic                         we,
  input  logic [DATA_W-1:0]            data,
  output logic [DATA_W-1:0]            data0,
  output logic [DATA_W-1:0]            data1,
  input  logic                         push,
  input  logic                         pop,
  input  logic [MOVE_W-1:0]            move,
  input  logic                         hist_clr,
  output logic [MOVE_W-1:0]            top,
  output logic [DW-1:0]                cnt,
  output logic [HIST_DEPTH*MOVE_W-1:0] ord,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         unf,
  output logic                         comp
);

  logic [NREG-1:0][DATA_W-1:0]        rf;
  logic [HIST_DEPTH-1:0][MOVE_W-1:0]  ent;
  logic [DW-1:0]                      tidx;

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf    <= '0;
      rf[0] <= INIT_STATE[DATA_W-1:0];
      rf[1] <= GOAL_STATE[DATA_W-1:0];
    end else if (we && (int'(dst) < NREG)) begin
      rf[dst] <= data;
    end
  end

  always_comb begin
    data0 = '0;
    data1 = '0;
    if (int'(src0) < NREG) data0 = rf[src0];
    if (int'(src1) < NREG) data1 = rf[src1];
`ifdef REGFILE_BYPASS_EN
    if (we && (int'(dst) < NREG) && (src0 == dst)) data0 = data;
    if (we && (int'(dst) < NREG) && (src1 == dst)) data1 = data;
`endif
  end

  // comp always comes from the stored register; it is never forwarded
  assign comp = rf[COMP_IDX][0];

  // ---------------- history stack ----------------
  assign full  = (cnt == DW'(HIST_DEPTH));
  assign empty = (cnt == '0);
  assign tidx  = cnt - DW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (hist_clr) begin
      ent <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (push && pop) begin
      if (!empty) begin
        ent[tidx] <= move;       // replace top, depth unchanged
      end else begin
        ent[0] <= move;          // an empty stack treats push+pop as a plain push
        cnt    <= DW'(1);
      end
    end else if (push) begin
      if (full) begin
        ovf <= 1'b1;
      end else begin
        ent[cnt] <= move;
        cnt      <= cnt + DW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        ent[tidx] <= '0;         // keep entries above the top at 0 so ord needs no masking
        cnt       <= tidx;
      end
    end
  end

  always_comb begin
    top = '0;
    if (!empty) top = ent[tidx];
  end

  assign ord = ent;

endmodule

// File: tb/tb_regfile_hist.sv
// tb_regfile_hist: directed bench for regfile_hist. Expected values go into a
// scoreboard queue when the stimulus is driven. They are popped and compared
// once the DUT output is ready.
module tb_regfile_hist;
  localparam logic [25:0] INIT = 26'h0A720C1;
  localparam logic [25:0] GOAL = 26'h0000053;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  src0, src1, dst;
  logic        we;
  logic [25:0] data, data0, data1;
  logic        push, pop, hist_clr;
  logic [1:0]  move, top;
  logic [4:0]  cnt;
  logic [39:0] ord;
  logic        full, empty, ovf, unf, comp;

  regfile_hist #(.INIT_STATE(INIT), .GOAL_STATE(GOAL)) dut (
    .clk(clk), .rst_n(rst_n), .src0(src0), .src1(src1), .dst(dst), .we(we),
    .data(data), .data0(data0), .data1(data1), .push(push), .pop(pop),
    .move(move), .hist_clr(hist_clr), .top(top), .cnt(cnt), .ord(ord),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf), .comp(comp));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [39:0] m;

  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty got %0h required <entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s got %0h required %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; src0 = '0; src1 = 5'd1; dst = '0; we = 1'b0; data = '0;
    push = 1'b0; pop = 1'b0; move = '0; hist_clr = 1'b0; m = '0;
    #12 rst_n = 1'b1;
    step();

    // reset state
    expect_v("rst_reg0", 64'(INIT));  chk(64'(data0));
    expect_v("rst_reg1", 64'(GOAL));  chk(64'(data1));
    for (int a = 2; a < 32; a++) begin
      src0 = 5'(a);
      #1;
      expect_v($sformatf("rst_reg%0d", a), 64'd0);
      chk(64'(data0));
    end
    expect_v("rst_cnt", 64'd0);   chk(64'(cnt));
    expect_v("rst_empty", 64'd1); chk(64'(empty));
    expect_v("rst_full", 64'd0);  chk(64'(full));
    expect_v("rst_top", 64'd0);   chk(64'(top));
    expect_v("rst_ord", 64'd0);   chk(64'(ord));
    expect_v("rst_comp", 64'd0);  chk(64'(comp));

    // write reg5, then read it in the same cycle and in the next cycle
    we = 1'b1; dst = 5'd5; data = 26'h3FFFFFF; src0 = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    expect_v("wr_same_cycle", 64'h3FFFFFF);
`else
    expect_v("wr_same_cycle", 64'd0);
`endif
    chk(64'(data0));
    step();
    we = 1'b0;
    #1;
    expect_v("wr_next_cycle", 64'h3FFFFFF); chk(64'(data0));

    // push 1, 2, 3 and then pop once
    for (int k = 1; k <= 3; k++) begin
      push = 1'b1; move = 2'(k);
      step();
    end
    push = 1'b0;
    expect_v("push3_cnt", 64'd3);      chk(64'(cnt));
    expect_v("push3_top", 64'd3);      chk(64'(top));
    expect_v("push3_ord", 64'b111001); chk(64'(ord[5:0]));
    pop = 1'b1; step(); pop = 1'b0;
    expect_v("pop_cnt", 64'd2);    chk(64'(cnt));
    expect_v("pop_top", 64'd2);    chk(64'(top));
    expect_v("pop_ord54", 64'd0);  chk(64'(ord[5:4]));

    // push and pop together: replace the top, then the empty case
    push = 1'b1; pop = 1'b1; move = 2'd0; step();
    push = 1'b0; pop = 1'b0;
    expect_v("repl_cnt", 64'd2); chk(64'(cnt));
    expect_v("repl_top", 64'd0); chk(64'(top));
    pop = 1'b1; step(); step(); pop = 1'b0;
    expect_v("drain_empty", 64'd1); chk(64'(empty));
    push = 1'b1; pop = 1'b1; move = 2'd2; step();
    push = 1'b0; pop = 1'b0;
    expect_v("pp_empty_cnt", 64'd1); chk(64'(cnt));
    expect_v("pp_empty_top", 64'd2); chk(64'(top));

    // overflow and underflow
    hist_clr = 1'b1; step(); hist_clr = 1'b0;
    expect_v("clr_cnt", 64'd0); chk(64'(cnt));
    m = '0;
    for (int i = 0; i < 20; i++) begin
      push = 1'b1; move = 2'((i % 3) + 1);
      m[i*2 +: 2] = 2'((i % 3) + 1);
      step();
    end
    expect_v("fill_cnt", 64'd20);  chk(64'(cnt));
    expect_v("fill_full", 64'd1);  chk(64'(full));
    expect_v("fill_ovf", 64'd0);   chk(64'(ovf));
    expect_v("fill_ord", 64'(m));  chk(64'(ord));
    move = 2'd0; step(); push = 1'b0;   // 21st push, with a move that differs from the stored ones
    expect_v("ovf_cnt", 64'd20);   chk(64'(cnt));
    expect_v("ovf_flag", 64'd1);   chk(64'(ovf));
    expect_v("ovf_ord", 64'(m));   chk(64'(ord));
    expect_v("ovf_top", 64'd2);    chk(64'(top));
    pop = 1'b1;
    for (int i = 0; i < 20; i++) step();
    expect_v("drain20_cnt", 64'd0); chk(64'(cnt));
    expect_v("drain20_unf", 64'd0); chk(64'(unf));
    expect_v("drain20_ord", 64'd0); chk(64'(ord));
    step(); pop = 1'b0;
    expect_v("unf_cnt", 64'd0);  chk(64'(cnt));
    expect_v("unf_flag", 64'd1); chk(64'(unf));
    expect_v("unf_ovf", 64'd1);  chk(64'(ovf));
    hist_clr = 1'b1; push = 1'b1; move = 2'd1; step();
    hist_clr = 1'b0; push = 1'b0;
    expect_v("hclr_ovf", 64'd0); chk(64'(ovf));
    expect_v("hclr_unf", 64'd0); chk(64'(unf));
    expect_v("hclr_cnt", 64'd0); chk(64'(cnt));

    // comp, followed by an asynchronous reset between clock edges
    we = 1'b1; dst = 5'd30; data = 26'd1;
    push = 1'b1; move = 2'd3;
    step();
    we = 1'b0;
    step();
    push = 1'b0;
    expect_v("comp_set", 64'd1); chk(64'(comp));
    expect_v("pre_rst_cnt", 64'd2); chk(64'(cnt));
    #2 rst_n = 1'b0;
    #1;
    expect_v("arst_comp", 64'd0); chk(64'(comp));
    expect_v("arst_cnt", 64'd0);  chk(64'(cnt));
    expect_v("arst_ord", 64'd0);  chk(64'(ord));
    src0 = 5'd0;
    #1;
    expect_v("arst_reg0", 64'(INIT)); chk(64'(data0));
    #1 rst_n = 1'b1;
    push = 1'b1; move = 2'd3; step(); push = 1'b0;
    expect_v("post_rst_cnt", 64'd1); chk(64'(cnt));
    expect_v("post_rst_top", 64'd3); chk(64'(top));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
